cordic_seq: RTL

CORDIC_SEQ -- requirements
Module: cordic_seq

---
 rtl/cordic_seq_if.sv | 24 ++
 rtl/cordic_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cordic_seq_if.sv
// Request/result handshake bundle between a client and the cordic_seq sequencer.
// The sequencer sits on the slave side; the client drives the master side.
interface cordic_seq_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] x_in;
  logic signed [31:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] mod_out;
  logic signed [31:0] angle_out;
  logic               ovf;
  logic               busy;

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mod_out, angle_out, ovf, busy
  );

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mod_out, angle_out, ovf, busy
  );
endinterface

// File: rtl/cordic_seq.sv
// Sequencer around a rec2pol CORDIC core: folds the left half-plane into the
// right, runs the core for NITER cycles, then restores a full-circle angle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// LOAD  | operands registered, one-cycle core_start pulse
// RUN   | core iterating, NITER cycles
// CAPT  | core result captured and angle unfolded
// DONE  | result held until out_ready
module cordic_seq #(
  parameter int NITER = 24
) (
  input  logic               clock,
  input  logic               reset,
  cordic_seq_if.slave        bus,
  output logic               core_start,
  output logic               core_enable,
  output logic signed [31:0] core_x,
  output logic signed [31:0] core_y,
  input  logic signed [31:0] core_mod,
  input  logic signed [31:0] core_angle
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

  localparam logic signed [31:0] MOST_NEG  = 32'sh8000_0000;
  localparam logic signed [31:0] MOST_POS  = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] HALF_TURN = 32'sh5A00_0000;
  localparam logic [5:0]         LAST_ITER = 6'(NITER - 1);

  state_t             state_q;
  logic [5:0]         iter_q;
  logic               flip_q;
  logic               qs_q;
  logic               ovf_flag_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               out_valid_q;
  logic               ovf_q;
  logic               core_start_q;
  logic               core_enable_q;
  logic signed [31:0] core_x_q;
  logic signed [31:0] core_y_q;
  logic signed [31:0] mod_q;
  logic signed [31:0] angle_q;

  logic signed [31:0] angle_half;
  logic signed [31:0] angle_unfold;

  function automatic logic signed [31:0] neg_sat(input logic signed [31:0] v);
    return (v == MOST_NEG) ? MOST_POS : -v;
  endfunction

  // Core angle is 8Q24; halving gives 9Q23, then undo the half-plane fold.
  assign angle_half   = core_angle >>> 1;
  assign angle_unfold = qs_q ? (angle_half + HALF_TURN) : (angle_half - HALF_TURN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      iter_q        <= '0;
      flip_q        <= 1'b0;
      qs_q          <= 1'b0;
      ovf_flag_q    <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      ovf_q         <= 1'b0;
      core_start_q  <= 1'b0;
      core_enable_q <= 1'b0;
      core_x_q      <= '0;
      core_y_q      <= '0;
      mod_q         <= '0;
      angle_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q       <= LOAD;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            core_start_q  <= 1'b1;
            core_enable_q <= 1'b1;
            iter_q        <= '0;
            qs_q          <= ~bus.y_in[31];
            if (bus.x_in[31]) begin
              core_x_q   <= neg_sat(bus.x_in);
              core_y_q   <= neg_sat(bus.y_in);
              flip_q     <= 1'b1;
              ovf_flag_q <= (bus.x_in == MOST_NEG) || (bus.y_in == MOST_NEG);
            end else begin
              core_x_q   <= bus.x_in;
              core_y_q   <= bus.y_in;
              flip_q     <= 1'b0;
              ovf_flag_q <= 1'b0;
            end
          end
        end
        LOAD: begin
          state_q      <= RUN;
          core_start_q <= 1'b0;
          iter_q       <= '0;
        end
        RUN: begin
          iter_q <= iter_q + 6'd1;
          if (iter_q == LAST_ITER) begin
            state_q       <= CAPT;
            core_enable_q <= 1'b0;
          end
        end
        CAPT: begin
          state_q     <= DONE;
          mod_q       <= core_mod;
          angle_q     <= flip_q ? angle_unfold : angle_half;
          ovf_q       <= ovf_flag_q;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mod_out   = mod_q;
  assign bus.angle_out = angle_q;
  assign bus.ovf       = ovf_q;
  assign core_start    = core_start_q;
  assign core_enable   = core_enable_q;
  assign core_x        = core_x_q;
  assign core_y        = core_y_q;

endmodule
